// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file, registered read addresses, highest write port wins.
// Optional sticky write-collision flag is built when REGFILE_WCONFLICT_EN is defined.
module regfile_mp #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 8,
  parameter int NRD   = 6,
  parameter int NWR   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD-1:0]    ren,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rvalid,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR*DW-1:0] wdata,
  output logic              wconflict
);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [NRD*AW-1:0] r_raddr;
  logic [NRD-1:0]    r_rvalid;
  logic [NRD*DW-1:0] w_rdata;

  // Entry update: ports scanned low to high so the highest enabled port lands last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int j = 0; j < NWR; j++) begin
          if (wen[j] && (waddr[j*AW +: AW] == AW'(e))) begin
            r_mem[e] <= wdata[j*DW +: DW];
          end
        end
      end
    end
  end

  // Read address and valid capture, unconditional on ren
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raddr  <= '0;
      r_rvalid <= '0;
    end else begin
      r_raddr  <= raddr;
      r_rvalid <= ren;
    end
  end

  // Combinational read; an address with no implemented entry falls through to zero
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_raddr[i*AW +: AW] == AW'(e)) begin
          w_rdata[i*DW +: DW] = r_mem[e];
        end else begin
          w_rdata[i*DW +: DW] = w_rdata[i*DW +: DW];
        end
      end
    end
  end

  assign rdata  = w_rdata;
  assign rvalid = r_rvalid;

`ifdef REGFILE_WCONFLICT_EN
  logic w_conflict;
  logic r_wconflict;

  // Any pair of enabled ports sharing an address, in range or not
  always_comb begin
    w_conflict = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (wen[j] && wen[k] && (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
          w_conflict = 1'b1;
        end else begin
          w_conflict = w_conflict;
        end
      end
    end
  end

  // Sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wconflict <= 1'b0;
    end else begin
      r_wconflict <= r_wconflict | w_conflict;
    end
  end

  assign wconflict = r_wconflict;
`else
  assign wconflict = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default build checked every cycle against an array model,
// plus DEPTH=6 and 16-bit builds with directed literal checks.
module tb_regfile_mp;
  localparam int DW = 8, AW = 3, DEPTH = 8, NRD = 6, NWR = 4;
`ifdef REGFILE_WCONFLICT_EN
  localparam logic EXP_CONF = 1'b1;
`else
  localparam logic EXP_CONF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [NRD-1:0] ren = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0] rvalid;
  logic [NWR-1:0] wen = '0;
  logic [NWR*AW-1:0] waddr = '0;
  logic [NWR*DW-1:0] wdata = '0;
  logic wconflict;

  regfile_mp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) u_dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wconflict(wconflict));

  logic [5:0] ren6 = '0;
  logic [17:0] raddr6 = '0;
  logic [47:0] rdata6;
  logic [5:0] rvalid6;
  logic [3:0] wen6 = '0;
  logic [11:0] waddr6 = '0;
  logic [31:0] wdata6 = '0;
  logic wconflict6;

  regfile_mp #(.DW(8), .AW(3), .DEPTH(6), .NRD(6), .NWR(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .ren(ren6), .raddr(raddr6), .rdata(rdata6), .rvalid(rvalid6),
    .wen(wen6), .waddr(waddr6), .wdata(wdata6), .wconflict(wconflict6));

  logic [1:0] ren16 = '0;
  logic [7:0] raddr16 = '0;
  logic [31:0] rdata16;
  logic [1:0] rvalid16;
  logic [0:0] wen16 = '0;
  logic [3:0] waddr16 = '0;
  logic [15:0] wdata16 = '0;
  logic wconflict16;

  regfile_mp #(.DW(16), .AW(4), .DEPTH(16), .NRD(2), .NWR(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ren(ren16), .raddr(raddr16), .rdata(rdata16), .rvalid(rvalid16),
    .wen(wen16), .waddr(waddr16), .wdata(wdata16), .wconflict(wconflict16));

  // Reference model of the default build: a plain array indexed by address
  logic [DW-1:0] m_mem [2**AW];
  logic [AW-1:0] m_raddr [NRD];
  logic [NRD-1:0] m_rvalid;
  logic m_conf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 2**AW; a++) m_mem[a] <= '0;
      for (int i = 0; i < NRD; i++) m_raddr[i] <= '0;
      m_rvalid <= '0;
      m_conf <= 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wen[j] && (int'(waddr[j*AW +: AW]) < DEPTH)) m_mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];
      for (int j = 0; j < NWR; j++)
        for (int k = j + 1; k < NWR; k++)
          if (EXP_CONF && wen[j] && wen[k] && waddr[j*AW +: AW] == waddr[k*AW +: AW]) m_conf <= 1'b1;
      for (int i = 0; i < NRD; i++) m_raddr[i] <= raddr[i*AW +: AW];
      m_rvalid <= ren;
    end
  end

  // Per-cycle comparison of the default build against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NRD*DW-1:0] exp_rd;
      for (int i = 0; i < NRD; i++)
        exp_rd[i*DW +: DW] = (int'(m_raddr[i]) < DEPTH) ? m_mem[m_raddr[i]] : '0;
      checks = checks + 3;
      if (rdata !== exp_rd) begin
        errors++;
        $display("FAIL model_rdata t=%0t got %h expected %h", $time, rdata, exp_rd);
      end
      if (rvalid !== m_rvalid) begin
        errors++;
        $display("FAIL model_rvalid t=%0t got %b expected %b", $time, rvalid, m_rvalid);
      end
      if (wconflict !== m_conf) begin
        errors++;
        $display("FAIL model_wconflict t=%0t got %b expected %b", $time, wconflict, m_conf);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [7:0] d);
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    ren = 6'b111111;
    for (int i = 0; i < NRD; i++) set_rd(i, i);
    @(negedge clk);
    chk("reset_rvalid", 32'(rvalid), 32'h3F);
    for (int i = 0; i < NRD; i++) chk("reset_rdata", 32'(rdata[i*DW +: DW]), 32'h00);

    // Write and read the same entry in one cycle
    wen = 4'b0001;
    set_wr(0, 3, 8'hA5);
    set_rd(2, 3);
    @(negedge clk);
    chk("vis_rdata2", 32'(rdata[2*DW +: DW]), 32'hA5);
    chk("vis_rvalid2", 32'(rvalid[2]), 32'h1);

    // Same-entry collision: port 3 must win
    wen = 4'b1111;
    set_wr(0, 5, 8'h11); set_wr(1, 5, 8'h22); set_wr(2, 6, 8'h33); set_wr(3, 5, 8'h44);
    ren = '0;
    @(negedge clk);
    wen = '0;
    ren = 6'b000011;
    set_rd(0, 5); set_rd(1, 6);
    @(negedge clk);
    chk("prio_entry5", 32'(rdata[0 +: DW]), 32'h44);
    chk("prio_entry6", 32'(rdata[DW +: DW]), 32'h33);
    chk("prio_rvalid", 32'(rvalid), 32'h03);
    chk("prio_wconflict", 32'(wconflict), 32'(EXP_CONF));
    repeat (10) @(negedge clk);
    chk("prio_wconflict_sticky", 32'(wconflict), 32'(EXP_CONF));

    // DEPTH=6 build: writes to 6/7 ignored, reads of 7 return zero
    wen6 = 4'b1111;
    waddr6 = {3'd3, 3'd2, 3'd1, 3'd0};
    wdata6 = {8'h13, 8'h12, 8'h11, 8'h10};
    @(negedge clk);
    wen6 = 4'b0111;
    waddr6 = {3'd0, 3'd7, 3'd5, 3'd4};
    wdata6 = {8'h00, 8'hFF, 8'h15, 8'h14};
    @(negedge clk);
    wen6 = 4'b0001;
    waddr6 = {3'd0, 3'd0, 3'd0, 3'd7};
    wdata6 = {8'h00, 8'h00, 8'h00, 8'hFF};
    ren6 = 6'b111111;
    raddr6 = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    @(negedge clk);
    wen6 = '0;
    for (int i = 0; i < 6; i++) chk("oor_entry", 32'(rdata6[i*8 +: 8]), 32'(8'h10 + 8'(i)));
    chk("oor_no_conflict", 32'(wconflict6), 32'h0);
    ren6 = 6'b000011;
    raddr6 = {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd7};
    @(negedge clk);
    chk("oor_read7", 32'(rdata6[0 +: 8]), 32'h00);
    chk("oor_read6", 32'(rdata6[8 +: 8]), 32'h00);
    chk("oor_rvalid", 32'(rvalid6), 32'h03);
    wen6 = 4'b0011;
    waddr6 = {3'd0, 3'd0, 3'd7, 3'd7};
    @(negedge clk);
    wen6 = '0;
    chk("oor_conflict", 32'(wconflict6), 32'(EXP_CONF));

    // 16-bit, 16-entry, 2-read, 1-write build
    wen16 = 1'b1; waddr16 = 4'd15; wdata16 = 16'hBEEF;
    @(negedge clk);
    wen16 = 1'b0;
    ren16 = 2'b11; raddr16 = {4'd15, 4'd15};
    @(negedge clk);
    chk("p16_rdata0", 32'(rdata16[0 +: 16]), 32'hBEEF);
    chk("p16_rdata1", 32'(rdata16[16 +: 16]), 32'hBEEF);
    chk("p16_rvalid", 32'(rvalid16), 32'h3);

    // Fill every entry, then assert reset between edges with writes pending
    ren = 6'b111111;
    for (int i = 0; i < NRD; i++) set_rd(i, i);
    wen = 4'b1111;
    for (int j = 0; j < NWR; j++) set_wr(j, j, 8'hC3);
    @(negedge clk);
    for (int j = 0; j < NWR; j++) set_wr(j, j + 4, 8'hC3);
    @(negedge clk);
    for (int i = 0; i < NRD; i++) chk("fill_rdata", 32'(rdata[i*DW +: DW]), 32'hC3);
    for (int j = 0; j < NWR; j++) set_wr(j, j, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdata", 32'(rdata[31:0]), 32'h0);
    chk("arst_rdata_hi", 32'(rdata[47:32]), 32'h0);
    chk("arst_rvalid", 32'(rvalid), 32'h0);
    chk("arst_wconflict", 32'(wconflict), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wen = '0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NRD; i++) chk("post_rst_entry", 32'(rdata[i*DW +: DW]), 32'h00);
    chk("post_rst_rvalid", 32'(rvalid), 32'h3F);
    set_rd(0, 6); set_rd(1, 7);
    @(negedge clk);
    chk("post_rst_entry6", 32'(rdata[0 +: DW]), 32'h00);
    chk("post_rst_entry7", 32'(rdata[DW +: DW]), 32'h00);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
